// File: rtl/enigma_pkg.sv
// Shared widths, entry layout and QoS encoding for the ENIGMA port-C sink.
package enigma_pkg;

  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned ID_W      = 6;
  localparam int unsigned QOS_W     = 2;

  localparam logic [QOS_W-1:0] QOS_EXPRESS = 2'b11;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ID_W-1:0]      id;
    logic [QOS_W-1:0]     qos;
  } entry_t;

endpackage

// File: rtl/enigma_sink_fifo.sv
// Power-of-two FIFO of entry_t with wrap-bit pointers and a combinational head.
module enigma_sink_fifo
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/enigma_sink.sv
// Port-C receive endpoint: outstanding-ID scoreboard, beat queue and ID release.
// Define ENIGMA_SINK_EXPRESS_EN to add a 2-entry express queue for QOS_EXPRESS beats.
module enigma_sink
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_c,
  input  logic [PAYLOAD_W-1:0] payload_c,
  input  logic [ID_W-1:0]      id_c,
  input  logic [QOS_W-1:0]     qos_c,
  output logic                 ready_c,
  output logic                 conflict_c,
  output logic                 release_c,
  output logic [ID_W-1:0]      releaseid_c,
  output logic                 dout_valid,
  output logic [PAYLOAD_W-1:0] dout_payload,
  output logic [ID_W-1:0]      dout_id,
  output logic [QOS_W-1:0]     dout_qos,
  input  logic                 dout_ready
);

  logic [(1<<ID_W)-1:0] busy;
  entry_t               in_entry;
  entry_t               head;
  entry_t               main_head;
  logic                 main_full;
  logic                 main_empty;
  logic                 main_push;
  logic                 main_pop;
  logic                 accept;
  logic                 pop;

  assign in_entry   = '{payload: payload_c, id: id_c, qos: qos_c};
  assign conflict_c = valid_c & busy[id_c];
  assign accept     = valid_c & ready_c;
  // pop never looks at ready_c, so a full queue can still drain in the refusing cycle
  assign pop        = dout_valid & dout_ready;

`ifdef ENIGMA_SINK_EXPRESS_EN
  logic   is_express;
  logic   exp_full;
  logic   exp_empty;
  logic   exp_push;
  logic   exp_pop;
  entry_t exp_head;

  assign is_express = (qos_c == QOS_EXPRESS);
  assign ready_c    = ~conflict_c & ~(is_express ? exp_full : main_full);
  assign exp_push   = accept & is_express;
  assign main_push  = accept & ~is_express;
  assign exp_pop    = pop & ~exp_empty;
  assign main_pop   = pop & exp_empty;
  assign head       = exp_empty ? main_head : exp_head;
  assign dout_valid = ~(main_empty & exp_empty);

  enigma_sink_fifo #(.DEPTH(2)) u_exp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (exp_push),
    .push_entry (in_entry),
    .pop        (exp_pop),
    .full       (exp_full),
    .empty      (exp_empty),
    .head       (exp_head)
  );
`else
  assign ready_c    = ~conflict_c & ~main_full;
  assign main_push  = accept;
  assign main_pop   = pop;
  assign head       = main_head;
  assign dout_valid = ~main_empty;
`endif

  enigma_sink_fifo #(.DEPTH(DEPTH)) u_main_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (main_push),
    .push_entry (in_entry),
    .pop        (main_pop),
    .full       (main_full),
    .empty      (main_empty),
    .head       (main_head)
  );

  assign dout_payload = head.payload;
  assign dout_id      = head.id;
  assign dout_qos     = head.qos;

  // A popped ID is always busy, so it can never equal an accepted id_c in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      release_c   <= 1'b0;
      releaseid_c <= '0;
    end else begin
      if (pop) begin
        busy[head.id] <= 1'b0;
        releaseid_c   <= head.id;
      end
      if (accept) begin
        busy[id_c] <= 1'b1;
      end
      release_c <= pop;
    end
  end

endmodule

// File: tb/tb_enigma_sink.sv
// Directed and streaming bench for enigma_sink against a queue-based reference model.
module tb_enigma_sink;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_c;
  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         dout_valid;
  logic [127:0] dout_payload;
  logic [5:0]   dout_id;
  logic [1:0]   dout_qos;
  logic         dout_ready;

  enigma_sink #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_c      (valid_c),
    .payload_c    (payload_c),
    .id_c         (id_c),
    .qos_c        (qos_c),
    .ready_c      (ready_c),
    .conflict_c   (conflict_c),
    .release_c    (release_c),
    .releaseid_c  (releaseid_c),
    .dout_valid   (dout_valid),
    .dout_payload (dout_payload),
    .dout_id      (dout_id),
    .dout_qos     (dout_qos),
    .dout_ready   (dout_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of queued beats plus a set of outstanding IDs.
  typedef struct {
    bit [127:0] p;
    bit [5:0]   id;
    bit [1:0]   q;
  } ment_t;

  ment_t    mq[$];
  bit       mbusy[64];
  bit       m_rel;
  bit [5:0] m_relid;
  int       m_acc_total;
  int       acc_count[64];
  int       dut_rel_count[64];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_rel   = 1'b0;
      m_relid = '0;
    end else begin
      bit    do_acc;
      bit    do_pop;
      ment_t e;
      do_acc = valid_c && !mbusy[id_c] && (mq.size() < DEPTH);
      do_pop = (mq.size() > 0) && dout_ready;
      m_rel  = do_pop;
      if (do_pop) begin
        e = mq.pop_front();
        mbusy[e.id] = 1'b0;
        m_relid = e.id;
      end
      if (do_acc) begin
        e.p = payload_c;
        e.id = id_c;
        e.q = qos_c;
        mq.push_back(e);
        mbusy[id_c] = 1'b1;
        m_acc_total++;
        acc_count[id_c]++;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_conf;
    exp_conf = valid_c && mbusy[id_c];
    chk("conflict_c", conflict_c, exp_conf);
    chk("ready_c", ready_c, !exp_conf && (mq.size() < DEPTH));
    chk("dout_valid", dout_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("dout_id", dout_id, mq[0].id);
      chk("dout_payload", dout_payload, mq[0].p);
      chk("dout_qos", dout_qos, mq[0].q);
    end
    chk("release_c", release_c, m_rel);
    if (m_rel) chk("releaseid_c", releaseid_c, m_relid);
    if (release_c) dut_rel_count[releaseid_c]++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit v, input bit [5:0] id, input bit [127:0] p, input bit [1:0] q);
    valid_c   = v;
    id_c      = id;
    payload_c = p;
    qos_c     = q;
  endtask

  initial begin
    int cyc;
    int bad;
    int sum;
    bit [5:0] rid;
    rst = 1'b1;
    dout_ready = 1'b0;
    beat(0, 6'h00, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_c, 1'b1);
    chk("rst_conflict", conflict_c, 1'b0);
    chk("rst_release", release_c, 1'b0);
    chk("rst_releaseid", releaseid_c, 6'h00);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout_payload", dout_payload, 128'h0);
    chk("rst_dout_id", dout_id, 6'h00);
    chk("rst_dout_qos", dout_qos, 2'b00);
    rst = 1'b0;
    step();

    // single beat, id 05
    dout_ready = 1'b1;
    beat(1, 6'h05, 128'hCAFE_0005, 2'b01);
    step();
    beat(0, 6'h05, 128'hCAFE_0005, 2'b01);
    chk("single_dv", dout_valid, 1'b1);
    chk("single_id", dout_id, 6'h05);
    chk("single_payload", dout_payload, 128'hCAFE_0005);
    step();
    chk("single_release", release_c, 1'b1);
    chk("single_releaseid", releaseid_c, 6'h05);
    chk("single_dv_after_pop", dout_valid, 1'b0);
    valid_c = 1'b1;
    #1;
    chk("single_busy_clear", conflict_c, 1'b0);
    valid_c = 1'b0;
    step();
    chk("single_release_once", release_c, 1'b0);

    // conflict on 21 while 01 still accepted
    dout_ready = 1'b0;
    beat(1, 6'h21, 128'h2121, 2'b10);
    step();
    chk("conf_conflict", conflict_c, 1'b1);
    chk("conf_ready", ready_c, 1'b0);
    beat(1, 6'h01, 128'h0101, 2'b00);
    #1;
    chk("conf_port_bit_ready", ready_c, 1'b1);
    chk("conf_port_bit_conflict", conflict_c, 1'b0);
    step();
    valid_c = 1'b0;
    chk("conf_head", dout_id, 6'h21);
    dout_ready = 1'b1;
    repeat (3) step();
    dout_ready = 1'b0;

    // fill, refuse fifth, pop, accept fifth across pointer wrap
    for (int i = 0; i < 4; i++) begin
      beat(1, 6'(i), 128'(32'hF000 + i), 2'(i));
      step();
    end
    beat(1, 6'h04, 128'hF004, 2'b00);
    #1;
    chk("fill_ready_full", ready_c, 1'b0);
    chk("fill_no_conflict", conflict_c, 1'b0);
    dout_ready = 1'b1;
    step();
    chk("fill_ready_after_pop", ready_c, 1'b1);
    step();
    valid_c = 1'b0;
    chk("fill_head_order", dout_id, 6'h02);
    repeat (4) step();
    dout_ready = 1'b0;

    // re-accept in the release cycle
    beat(1, 6'h0A, 128'h0A0A, 2'b11);
    step();
    valid_c = 1'b0;
    dout_ready = 1'b1;
    step();
    chk("reacc_release", release_c, 1'b1);
    chk("reacc_releaseid", releaseid_c, 6'h0A);
    beat(1, 6'h0A, 128'hBEEF, 2'b01);
    #1;
    chk("reacc_conflict", conflict_c, 1'b0);
    chk("reacc_ready", ready_c, 1'b1);
    dout_ready = 1'b0;
    step();
    valid_c = 1'b0;
    chk("reacc_dv", dout_valid, 1'b1);
    chk("reacc_payload", dout_payload, 128'hBEEF);
    dout_ready = 1'b1;
    repeat (2) step();

    // streaming: 100 accepted beats with random backpressure
    foreach (acc_count[i]) begin
      acc_count[i] = 0;
      dut_rel_count[i] = 0;
    end
    m_acc_total = 0;
    cyc = 0;
    while (m_acc_total < 100 && cyc < 3000) begin
      do rid = 6'($urandom_range(0, 63)); while (mbusy[rid]);
      beat($urandom_range(0, 3) != 0, rid,
           {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
      dout_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("stream_accepted", m_acc_total, 100);
    valid_c = 1'b0;
    dout_ready = 1'b1;
    repeat (8) step();
    bad = 0;
    sum = 0;
    foreach (acc_count[i]) begin
      if (dut_rel_count[i] != acc_count[i]) bad++;
      sum += dut_rel_count[i];
    end
    chk("stream_release_ids", bad, 0);
    chk("stream_release_total", sum, 100);
    chk("stream_drained", dout_valid, 1'b0);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      beat(1, 6'(i), '0, 2'b00);
      #0.1;
      if (conflict_c) bad++;
    end
    valid_c = 1'b0;
    chk("stream_busy_empty", bad, 0);
    step();

    // reset with three beats queued
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1, 6'(16 + i), 128'(32'hD000 + i), 2'b01);
      step();
    end
    valid_c = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstq_dout_valid", dout_valid, 1'b0);
    chk("rstq_release", release_c, 1'b0);
    chk("rstq_ready", ready_c, 1'b1);
    step();
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (3) begin
      step();
      chk("rstq_no_release", release_c, 1'b0);
    end
    beat(1, 6'h10, 128'h1010, 2'b10);
    #1;
    chk("rstq_reaccept_ready", ready_c, 1'b1);
    chk("rstq_reaccept_conflict", conflict_c, 1'b0);
    step();
    valid_c = 1'b0;
    chk("rstq_head", dout_id, 6'h10);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
